// File: rtl/matrix_led_pwm_scanner.sv
// ROWS x COLS LED matrix scanner with per-pixel PWM, inter-row blanking and a
// double-buffered frame store whose bank swap only happens at a frame boundary.
module matrix_led_pwm_scanner #(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int PWM_BITS     = 4,
    parameter int BLANK_CYCLES = 16,
    parameter int SLOT_CYCLES  = 100
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     wr_en,
    input  logic [$clog2(ROWS)-1:0]  wr_row,
    input  logic [COLS*PWM_BITS-1:0] wr_data,
    input  logic [COLS-1:0]          wr_mask,
    input  logic                     rd_en,
    input  logic [$clog2(ROWS)-1:0]  rd_row,
    output logic [COLS*PWM_BITS-1:0] rd_data,
    output logic                     rd_valid,
    input  logic                     swap_req,
    output logic                     swap_pending,
    output logic                     front_bank,
    output logic                     frame_start,
    output logic [ROWS-1:0]          row,
    output logic [COLS-1:0]          col
);
    localparam int RW = $clog2(ROWS);
    localparam int DW = COLS * PWM_BITS;
    localparam int P  = BLANK_CYCLES + SLOT_CYCLES * ((1 << PWM_BITS) - 1);
    localparam int TW = $clog2(P);
    localparam int SW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [TW-1:0]   T_LAST  = TW'(P - 1);
    localparam logic [TW-1:0]   T_LATCH = TW'(BLANK_CYCLES - 1);
    localparam logic [TW-1:0]   T_DRIVE = TW'(BLANK_CYCLES);
    localparam logic [RW-1:0]   R_LAST  = RW'(ROWS - 1);
    localparam logic [SW-1:0]   S_LAST  = SW'(SLOT_CYCLES - 1);
    localparam logic [ROWS-1:0] ROW_ONE = ROWS'(1);

    logic [DW-1:0]       bank [2][ROWS];
    logic [TW-1:0]       t, t_n;
    logic [RW-1:0]       row_idx, row_idx_n;
    logic [PWM_BITS-1:0] slot, slot_n;
    logic [SW-1:0]       sub, sub_n;
    logic [DW-1:0]       latch, latch_n;
    logic                row_end, boundary, drive_n;
    logic [ROWS-1:0]     row_n;
    logic [COLS-1:0]     col_n;
    logic                wr_ok, rd_ok;

    // Row addresses beyond ROWS only exist when ROWS is not a power of two.
    if ((1 << RW) == ROWS) begin : g_pow2
        assign wr_ok = 1'b1;
        assign rd_ok = 1'b1;
    end else begin : g_npow2
        assign wr_ok = (wr_row <= R_LAST);
        assign rd_ok = (rd_row <= R_LAST);
    end

    // Next-cycle scan position; row/col are registered from these so each
    // cycle's outputs match that cycle's own position and latch.
    always_comb begin
        row_end   = (t == T_LAST);
        boundary  = row_end && (row_idx == R_LAST);
        t_n       = row_end ? '0 : t + 1'b1;
        row_idx_n = row_idx;
        if (row_end) row_idx_n = (row_idx == R_LAST) ? '0 : row_idx + 1'b1;
        latch_n   = (t == T_LATCH) ? bank[front_bank][row_idx] : latch;
        slot_n    = slot;
        sub_n     = sub;
        if (t == T_LATCH || row_end) begin
            slot_n = '0;
            sub_n  = '0;
        end else if (t >= T_DRIVE) begin
            if (sub == S_LAST) begin
                sub_n  = '0;
                slot_n = slot + 1'b1;
            end else begin
                sub_n = sub + 1'b1;
            end
        end
        drive_n = (t_n >= T_DRIVE);
        row_n   = '0;
        col_n   = '0;
        if (enable && drive_n) begin
            row_n = ROW_ONE << row_idx_n;
            for (int c = 0; c < COLS; c++)
                col_n[c] = (latch_n[c*PWM_BITS +: PWM_BITS] > slot_n);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < 2; b++)
                for (int r = 0; r < ROWS; r++)
                    bank[b][r] <= '0;
            t            <= '0;
            row_idx      <= '0;
            slot         <= '0;
            sub          <= '0;
            latch        <= '0;
            front_bank   <= 1'b0;
            swap_pending <= 1'b0;
            frame_start  <= 1'b0;
            row          <= '0;
            col          <= '0;
            rd_data      <= '0;
            rd_valid     <= 1'b0;
        end else begin
            t           <= t_n;
            row_idx     <= row_idx_n;
            slot        <= slot_n;
            sub         <= sub_n;
            latch       <= latch_n;
            row         <= row_n;
            col         <= col_n;
            frame_start <= boundary;
            rd_valid    <= rd_en;
            if (rd_en) rd_data <= rd_ok ? bank[~front_bank][rd_row] : '0;
            // Back bank is taken from the pre-edge front_bank, so a write that
            // coincides with a swap lands in the newly displayed bank.
            if (wr_en && wr_ok) begin
                for (int c = 0; c < COLS; c++)
                    if (wr_mask[c])
                        bank[~front_bank][wr_row][c*PWM_BITS +: PWM_BITS] <=
                            wr_data[c*PWM_BITS +: PWM_BITS];
            end
            if (boundary) begin
                if (swap_pending || swap_req) front_bank <= ~front_bank;
                swap_pending <= 1'b0;
            end else if (swap_req) begin
                swap_pending <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_matrix_led_pwm_scanner.sv
// Bench for matrix_led_pwm_scanner: a cycle-level reference model pushes expected
// outputs into queues; a negedge monitor pops and compares them.
module tb_matrix_led_pwm_scanner;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;
    localparam int PB    = 2;
    localparam int BLANK = 2;
    localparam int SLOT  = 3;
    localparam int P     = BLANK + SLOT * ((1 << PB) - 1);
    localparam int FRAME = ROWS * P;
    localparam int DW    = COLS * PB;
    localparam int RW    = $clog2(ROWS);
    localparam int EXP_W = ROWS + COLS + 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            enable = 1'b1;
    logic            wr_en = 1'b0;
    logic            rd_en = 1'b0;
    logic            swap_req = 1'b0;
    logic [RW-1:0]   wr_row = '0;
    logic [RW-1:0]   rd_row = '0;
    logic [DW-1:0]   wr_data = '0;
    logic [COLS-1:0] wr_mask = '0;
    logic [DW-1:0]   rd_data;
    logic            rd_valid, swap_pending, front_bank, frame_start;
    logic [ROWS-1:0] row;
    logic [COLS-1:0] col;

    matrix_led_pwm_scanner #(
        .ROWS(ROWS), .COLS(COLS), .PWM_BITS(PB),
        .BLANK_CYCLES(BLANK), .SLOT_CYCLES(SLOT)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data), .wr_mask(wr_mask),
        .rd_en(rd_en), .rd_row(rd_row), .rd_data(rd_data), .rd_valid(rd_valid),
        .swap_req(swap_req), .swap_pending(swap_pending), .front_bank(front_bank),
        .frame_start(frame_start), .row(row), .col(col)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    logic [EXP_W-1:0] exp_q[$];
    logic [DW-1:0]    rd_q[$];
    logic [EXP_W-1:0] mon_e;

    // Reference model: position derived from a plain cycle count since reset.
    int m_cyc, m_front, m_pend;
    int m_bank[2][ROWS][COLS];
    int m_latch[COLS];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_cyc = 0; m_front = 0; m_pend = 0;
        for (int b = 0; b < 2; b++)
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) m_bank[b][r][c] = 0;
        for (int c = 0; c < COLS; c++) m_latch[c] = 0;
    endtask

    task automatic model_step();
        int t, ri, tn, rn, s;
        bit bnd;
        logic [ROWS-1:0] er;
        logic [COLS-1:0] ec;
        logic [DW-1:0] rv;
        t  = m_cyc % P;
        ri = (m_cyc / P) % ROWS;
        if (t == BLANK - 1)
            for (int c = 0; c < COLS; c++) m_latch[c] = m_bank[m_front][ri][c];
        if (rd_en) begin
            rv = '0;
            if (int'(rd_row) < ROWS)
                for (int c = 0; c < COLS; c++) rv[c*PB +: PB] = PB'(m_bank[1-m_front][rd_row][c]);
            rd_q.push_back(rv);
        end
        if (wr_en && int'(wr_row) < ROWS)
            for (int c = 0; c < COLS; c++)
                if (wr_mask[c]) m_bank[1-m_front][wr_row][c] = int'(wr_data[c*PB +: PB]);
        bnd = (t == P - 1) && (ri == ROWS - 1);
        if (bnd) begin
            if (m_pend != 0 || swap_req) m_front = 1 - m_front;
            m_pend = 0;
        end else if (swap_req) begin
            m_pend = 1;
        end
        m_cyc++;
        tn = m_cyc % P;
        rn = (m_cyc / P) % ROWS;
        er = '0;
        ec = '0;
        if (enable && tn >= BLANK) begin
            s = (tn - BLANK) / SLOT;
            er[rn] = 1'b1;
            for (int c = 0; c < COLS; c++) ec[c] = (m_latch[c] > s);
        end
        exp_q.push_back({er, ec, bnd, m_front[0], m_pend[0], rd_en});
    endtask

    always @(posedge clk) begin
        if (reset) model_reset();
        else model_step();
    end

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("row", 32'(row), 32'(mon_e[4+COLS +: ROWS]));
            check("col", 32'(col), 32'(mon_e[4 +: COLS]));
            check("frame_start", 32'(frame_start), 32'(mon_e[3]));
            check("front_bank", 32'(front_bank), 32'(mon_e[2]));
            check("swap_pending", 32'(swap_pending), 32'(mon_e[1]));
            check("rd_valid", 32'(rd_valid), 32'(mon_e[0]));
        end
        if (rd_valid) begin
            if (rd_q.size() > 0) check("rd_data", 32'(rd_data), 32'(rd_q.pop_front()));
            else check("rd_valid_unexpected", 32'(rd_valid), 32'(0));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic wait_phase(input int target);
        for (int i = 0; i < FRAME && (m_cyc % FRAME) != target; i++) tick();
    endtask

    task automatic write_row(input int r, input logic [DW-1:0] d, input logic [COLS-1:0] m);
        wr_en = 1'b1; wr_row = RW'(r); wr_data = d; wr_mask = m;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic read_row(input int r);
        rd_en = 1'b1; rd_row = RW'(r);
        tick();
        rd_en = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_row", 32'(row), 32'(0));
        check("rst_col", 32'(col), 32'(0));
        check("rst_front_bank", 32'(front_bank), 32'(0));
        check("rst_swap_pending", 32'(swap_pending), 32'(0));
        check("rst_frame_start", 32'(frame_start), 32'(0));
        check("rst_rd_valid", 32'(rd_valid), 32'(0));
        check("rst_rd_data", 32'(rd_data), 32'(0));
    endtask

    initial begin
        run(3);
        check_reset_outputs();
        reset = 1'b0;
        run(2 * FRAME + 5);

        // PWM levels 0,1,2,3 on row 0, made visible by a swap
        write_row(0, 8'hE4, 4'hF);
        pulse_swap();
        run(2 * FRAME);

        // Mid-frame swap with a repeated request while pending
        wait_phase(10);
        pulse_swap();
        run(5);
        pulse_swap();
        run(2 * FRAME);

        // Masked write then readback of the back bank
        write_row(2, 8'hFF, 4'b0101);
        read_row(2);
        run(2 * FRAME);

        // Write coinciding with the boundary swap
        wait_phase(FRAME - 1);
        wr_en = 1'b1; wr_row = 1; wr_data = 8'hB7; wr_mask = 4'hF; swap_req = 1'b1;
        tick();
        wr_en = 1'b0; swap_req = 1'b0;
        run(2 * FRAME);

        // Output gating
        enable = 1'b0;
        run(10);
        enable = 1'b1;
        run(FRAME);

        for (int i = 0; i < 3000; i++) begin
            wr_en    = ($urandom_range(0, 5) == 0);
            wr_row   = RW'($urandom_range(0, ROWS - 1));
            wr_data  = DW'($urandom);
            wr_mask  = COLS'($urandom);
            rd_en    = ($urandom_range(0, 3) == 0);
            rd_row   = RW'($urandom_range(0, ROWS - 1));
            swap_req = ($urandom_range(0, 60) == 0);
            enable   = ($urandom_range(0, 30) != 0);
            tick();
        end
        wr_en = 1'b0; rd_en = 1'b0; swap_req = 1'b0; enable = 1'b1;
        run(FRAME);

        // Asynchronous reset during row 3 DRIVE
        wait_phase(3 * P + 5);
        reset = 1'b1;
        #1;
        check("async_rst_row", 32'(row), 32'(0));
        check("async_rst_col", 32'(col), 32'(0));
        run(2);
        check_reset_outputs();
        reset = 1'b0;
        run(FRAME + 3);
        for (int r = 0; r < ROWS; r++) read_row(r);
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
